seg_display_scheduler: RTL

Time-shares one nibble-to-seven-segment decoder across NUM_DIGITS display digits (default 6, matching the board's six HEX displays). It accepts a packed hex value over a valid/ready handshake, then sequences the digits through the single decoder one per cycle. Leading-zero suppression and per-digit blanking are applied during the sequence. All digit outputs are committed together, so the displays never show a partially updated value. It sits between the datapath that produces values and the HEX display pins.

---
 rtl/seg_display_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_display_scheduler.sv
// Time-shares a single nibble-to-seven-segment decoder across NUM_DIGITS displays,
// scanning MSB to LSB into a shadow bank and committing all digits in one edge.
module seg_display_scheduler #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  state_e                         state_q;
  logic [IW-1:0]                  idx_q;
  logic                           zero_run_q;
  logic [4*NUM_DIGITS-1:0]        value_q;
  logic [NUM_DIGITS-1:0]          mask_q;
  logic                           lz_q;
  logic [NUM_DIGITS-1:0][6:0]     shadow_q;
  logic [NUM_DIGITS-1:0][6:0]     hex_q;
  logic                           load_ready_q;
  logic                           busy_q;
  logic                           done_q;

  logic [3:0]                     nib_d;
  logic [6:0]                     glyph_d;
  logic [6:0]                     digit_d;
  logic                           zero_run_d;
  logic [NUM_DIGITS-1:0][6:0]     commit_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      4'hF:    seg_decode = 7'h0E;
      default: seg_decode = BLANK;
    endcase
  endfunction

  // Shared decoder plus blanking for the digit currently selected by idx_q.
  always_comb begin
    nib_d      = value_q[4*idx_q +: 4];
    glyph_d    = seg_decode(nib_d);
    zero_run_d = zero_run_q && (nib_d == 4'h0);
    if (mask_q[idx_q]) begin
      digit_d = BLANK;
    end else if (lz_q && (idx_q != {IW{1'b0}}) && zero_run_d) begin
      digit_d = BLANK;
    end else begin
      digit_d = glyph_d;
    end
    commit_d    = shadow_q;
    commit_d[0] = digit_d;
  end

  // Handshake, scan sequencing, shadow fill and atomic commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= {IW{1'b0}};
      zero_run_q   <= 1'b0;
      value_q      <= {(4*NUM_DIGITS){1'b0}};
      mask_q       <= {NUM_DIGITS{1'b0}};
      lz_q         <= 1'b0;
      shadow_q     <= {(7*NUM_DIGITS){1'b0}};
      hex_q        <= {NUM_DIGITS{BLANK}};
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load_valid && load_ready_q) begin
            value_q      <= load_value;
            mask_q       <= blank_mask;
            lz_q         <= lz_suppress;
            idx_q        <= TOP_IDX;
            zero_run_q   <= 1'b1;
            state_q      <= S_SCAN;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end else begin
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        S_SCAN: begin
          shadow_q[idx_q] <= digit_d;
          zero_run_q      <= zero_run_d;
          if (idx_q == {IW{1'b0}}) begin
            hex_q        <= commit_d;
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            idx_q        <= idx_q - 1'b1;
            done_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          load_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign hex_out    = hex_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
